// File: rtl/iram_pkg.sv
// Shared types, address constants and helpers for the internal RAM access arbiter.
package iram_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        CAP  = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } iram_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } requester_t;

    // Bit addresses at or above this value map onto bit-addressable SFRs.
    localparam logic [7:0] SFR_BASE      = 8'h80;
    // First byte of the bit-addressable RAM area (20h-2Fh).
    localparam logic [7:0] BIT_AREA_BASE = 8'h20;

    // Returns byte_in with bit idx replaced by val.
    function automatic logic [7:0] replace_bit(input logic [7:0] byte_in,
                                               input logic [2:0] idx,
                                               input logic       val);
        logic [7:0] result;
        result      = byte_in;
        result[idx] = val;
        return result;
    endfunction

endpackage

// File: rtl/iram_bit_map.sv
// 8051 bit-address decode: turns a (bit or byte) address into a RAM byte address
// and a bit index within that byte.
module iram_bit_map
    import iram_pkg::*;
(
    input  logic       is_bit,
    input  logic [7:0] addr,
    output logic [7:0] byte_addr,
    output logic [2:0] bit_idx
);

    // Low bit addresses land in the 20h-2Fh bit area; high ones on 8-aligned SFRs.
    always_comb begin
        byte_addr = addr;
        bit_idx   = addr[2:0];
        if (is_bit) begin
            if (addr < SFR_BASE) begin
                byte_addr = BIT_AREA_BASE + {4'b0000, addr[6:3]};
            end else begin
                byte_addr = {addr[7:3], 3'b000};
            end
        end
    end

endmodule

// File: rtl/iram_access_arbiter.sv
// Shares the single-port internal RAM/SFR array between the CPU and the debug port.
// Serves one access at a time, decodes bit addresses, and turns bit writes into
// a read-modify-write of the containing byte.
//
// state | meaning
// IDLE  | sample requests, arbitrate, latch winner's command
// CMD   | issue RAM strobe (read, or write for byte writes)
// CAP   | capture RAM read data; for bit writes build the modified byte
// WB    | write the modified byte back (bit writes only)
// DONE  | one-cycle ack to the granted requester
module iram_access_arbiter
    import iram_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_is_bit,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_wbit,
    output logic              cpu_ack,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_is_bit,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [7:0]        dbg_wdata,
    input  logic              dbg_wbit,
    output logic              dbg_ack,

    output logic [7:0]        rdata,
    output logic              rbit,

    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,

    output logic              busy
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    iram_state_t state;
    iram_state_t next_state;

    requester_t  owner;
    logic        lat_we;
    logic        lat_is_bit;
    logic        lat_wbit;
    logic [2:0]  lat_bit;
    logic [7:0]  starve_cnt;

    logic        grant_cpu;
    logic        grant_dbg;
    logic        grant_any;

    logic        sel_we;
    logic        sel_is_bit;
    logic [7:0]  sel_addr;
    logic [7:0]  sel_wdata;
    logic        sel_wbit;
    logic [7:0]  map_byte;
    logic [2:0]  map_bit;

    logic        ram_rd_d;
    logic        ram_wr_d;
    logic [7:0]  ram_wdata_d;
    logic [7:0]  ram_addr_d;
    logic        cpu_ack_d;
    logic        dbg_ack_d;
    logic [7:0]  rdata_d;
    logic        rbit_d;

    assign busy = (state != IDLE);

    // Arbitration: CPU first, unless debug has been starved for LIMIT CPU grants.
    always_comb begin
        grant_dbg = (state == IDLE) && dbg_req && (!cpu_req || (starve_cnt == LIMIT));
        grant_cpu = (state == IDLE) && cpu_req && !grant_dbg;
        grant_any = grant_cpu || grant_dbg;
    end

    // Route the winning requester's command towards the decoder and latches.
    always_comb begin
        sel_we     = grant_dbg ? dbg_we     : cpu_we;
        sel_is_bit = grant_dbg ? dbg_is_bit : cpu_is_bit;
        sel_addr   = grant_dbg ? dbg_addr   : cpu_addr;
        sel_wdata  = grant_dbg ? dbg_wdata  : cpu_wdata;
        sel_wbit   = grant_dbg ? dbg_wbit   : cpu_wbit;
    end

    iram_bit_map u_bit_map (
        .is_bit    (sel_is_bit),
        .addr      (sel_addr),
        .byte_addr (map_byte),
        .bit_idx   (map_bit)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; only bit writes take the CAP -> WB path.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (grant_any) next_state = CMD;
            CMD:  next_state = (lat_we && !lat_is_bit) ? DONE : CAP;
            CAP:  next_state = lat_we ? WB : DONE;
            WB:   next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: values the registered outputs take in the upcoming state.
    always_comb begin
        ram_rd_d    = 1'b0;
        ram_wr_d    = 1'b0;
        ram_wdata_d = 8'h00;
        ram_addr_d  = ram_addr;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        rdata_d     = rdata;
        rbit_d      = rbit;

        if (grant_any) begin
            ram_addr_d = map_byte;
            if (sel_we && !sel_is_bit) begin
                ram_wr_d    = 1'b1;
                ram_wdata_d = sel_wdata;
            end else begin
                ram_rd_d    = 1'b1;
            end
        end

        if (next_state == WB) begin
            ram_wr_d    = 1'b1;
            ram_wdata_d = replace_bit(ram_rdata, lat_bit, lat_wbit);
        end

        if (state == CAP && !lat_we) begin
            rdata_d = ram_rdata;
            if (lat_is_bit) rbit_d = ram_rdata[lat_bit];
        end

        if (next_state == DONE) begin
            cpu_ack_d = (owner == REQ_CPU);
            dbg_ack_d = (owner == REQ_DBG);
        end
    end

    // Registered outputs so RAM strobes and acks are glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_wdata <= 8'h00;
            ram_addr  <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            rdata     <= 8'h00;
            rbit      <= 1'b0;
        end else begin
            ram_rd    <= ram_rd_d;
            ram_wr    <= ram_wr_d;
            ram_wdata <= ram_wdata_d;
            ram_addr  <= ram_addr_d;
            cpu_ack   <= cpu_ack_d;
            dbg_ack   <= dbg_ack_d;
            rdata     <= rdata_d;
            rbit      <= rbit_d;
        end
    end

    // Latch the winner's command on grant; the requester may change inputs after ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner      <= REQ_CPU;
            lat_we     <= 1'b0;
            lat_is_bit <= 1'b0;
            lat_wbit   <= 1'b0;
            lat_bit    <= 3'd0;
        end else if (grant_any) begin
            owner      <= grant_dbg ? REQ_DBG : REQ_CPU;
            lat_we     <= sel_we;
            lat_is_bit <= sel_is_bit;
            lat_wbit   <= sel_wbit;
            lat_bit    <= map_bit;
        end
    end

    // Starvation counter: counts CPU wins over a waiting debug request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= 8'd0;
        end else if (state == IDLE) begin
            if (!dbg_req || grant_dbg) begin
                starve_cnt <= 8'd0;
            end else if (grant_cpu) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_iram_access_arbiter.sv
// Self-checking bench for iram_access_arbiter: directed scenarios plus random
// single-requester traffic against a byte-array reference of the RAM contents.
module tb_iram_access_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_is_bit, cpu_wbit, cpu_ack;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       dbg_req, dbg_we, dbg_is_bit, dbg_wbit, dbg_ack;
    logic [7:0] dbg_addr, dbg_wdata;
    logic [7:0] rdata;
    logic       rbit;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_rd, ram_wr, busy;

    logic       pl_en;
    logic [7:0] pl_addr, pl_data;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    iram_access_arbiter #(.STARVE_LIMIT(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_is_bit (cpu_is_bit),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wbit   (cpu_wbit),
        .cpu_ack    (cpu_ack),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_is_bit (dbg_is_bit),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_wbit   (dbg_wbit),
        .dbg_ack    (dbg_ack),
        .rdata      (rdata),
        .rbit       (rbit),
        .ram_addr   (ram_addr),
        .ram_rd     (ram_rd),
        .ram_wr     (ram_wr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .busy       (busy)
    );

    // Single-port RAM with one-cycle read latency, plus a preload path.
    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_wr) mem[ram_addr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobes must never overlap.
    always @(negedge clock) begin
        if (!reset && (ram_rd || ram_wr)) check("rd_wr_exclusive", 32'(ram_rd & ram_wr), 32'd0);
    end

    function automatic logic [7:0] ref_byte(input bit is_bit, input logic [7:0] a);
        if (!is_bit) return a;
        if (a < 128) return 8'(32 + a / 8);
        return 8'(a - a % 8);
    endfunction

    function automatic int ref_bit(input logic [7:0] a);
        return int'(a % 8);
    endfunction

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_is_bit = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wbit = 0;
        dbg_req = 0; dbg_we = 0; dbg_is_bit = 0; dbg_addr = 0; dbg_wdata = 0; dbg_wbit = 0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        pl_en = 1; pl_addr = a; pl_data = d;
        exp_mem[a] = d;
        @(negedge clock);
        pl_en = 0;
    endtask

    // One transaction by a single requester, checked against the reference model.
    task automatic run_txn(input bit use_dbg, input bit we, input bit is_bit,
                           input logic [7:0] addr, input logic [7:0] wdata, input bit wbit,
                           input string tag);
        int         n;
        int         exp_lat;
        int         bi;
        bit         acked, seen, wrong_ack;
        logic [7:0] first_addr, last_wdata, ba, new_byte;
        ba  = ref_byte(is_bit, addr);
        bi  = ref_bit(addr);
        exp_lat = (we && !is_bit) ? 2 : (we ? 4 : 3);
        new_byte = is_bit ? (wbit ? (exp_mem[ba] | 8'(1 << bi)) : (exp_mem[ba] & ~8'(1 << bi))) : wdata;
        @(negedge clock);
        if (use_dbg) begin
            dbg_we = we; dbg_is_bit = is_bit; dbg_addr = addr; dbg_wdata = wdata; dbg_wbit = wbit; dbg_req = 1;
        end else begin
            cpu_we = we; cpu_is_bit = is_bit; cpu_addr = addr; cpu_wdata = wdata; cpu_wbit = wbit; cpu_req = 1;
        end
        n = 0; acked = 0; seen = 0; wrong_ack = 0; first_addr = 8'hxx; last_wdata = 8'hxx;
        while (!acked && n < 20) begin
            @(negedge clock);
            n++;
            if (!seen && (ram_rd || ram_wr)) begin seen = 1; first_addr = ram_addr; end
            if (ram_wr) last_wdata = ram_wdata;
            if (use_dbg ? dbg_ack : cpu_ack) acked = 1;
            if (use_dbg ? cpu_ack : dbg_ack) wrong_ack = 1;
        end
        cpu_req = 0; dbg_req = 0;
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_ram_addr"}, 32'(first_addr), 32'(ba));
        check({tag, "_other_ack"}, 32'(wrong_ack), 32'd0);
        if (we) begin
            check({tag, "_ram_wdata"}, 32'(last_wdata), 32'(new_byte));
            exp_mem[ba] = new_byte;
        end else begin
            check({tag, "_rdata"}, 32'(rdata), 32'(exp_mem[ba]));
            if (is_bit) check({tag, "_rbit"}, 32'(rbit), 32'((exp_mem[ba] >> bi) & 8'd1));
        end
    endtask

    initial begin
        int         cpu_cnt, dbg_seen, n;
        int         order [$];
        int         starve_runs [$];
        bit         got_wr;
        logic [7:0] keep;

        reset = 1; pl_en = 0; pl_addr = 0; pl_data = 0;
        idle_inputs();
        repeat (3) @(negedge clock);
        check("reset_cpu_ack",   32'(cpu_ack),   32'd0);
        check("reset_dbg_ack",   32'(dbg_ack),   32'd0);
        check("reset_rdata",     32'(rdata),     32'd0);
        check("reset_rbit",      32'(rbit),      32'd0);
        check("reset_ram_addr",  32'(ram_addr),  32'd0);
        check("reset_ram_rd",    32'(ram_rd),    32'd0);
        check("reset_ram_wr",    32'(ram_wr),    32'd0);
        check("reset_ram_wdata", 32'(ram_wdata), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        reset = 0;

        // Fill RAM and reference with the same random contents.
        @(negedge clock);
        pl_en = 1;
        for (int i = 0; i < 256; i++) begin
            pl_addr = 8'(i); pl_data = 8'($urandom_range(0, 255)); exp_mem[i] = pl_data;
            @(negedge clock);
        end
        pl_en = 0;

        run_txn(0, 1, 0, 8'h30, 8'h5A, 0, "byte_wr_30");
        run_txn(0, 0, 0, 8'h30, 8'h00, 0, "byte_rd_30");
        check("byte_rd_30_value", 32'(rdata), 32'h5A);

        preload(8'h21, 8'h00);
        run_txn(0, 1, 1, 8'h0B, 8'h00, 1, "bit_wr_0B");
        run_txn(0, 0, 0, 8'h21, 8'h00, 0, "bit_wr_0B_readback");
        check("bit_wr_0B_value", 32'(rdata), 32'h08);

        preload(8'hE0, 8'h80);
        run_txn(0, 0, 1, 8'hE7, 8'h00, 0, "bit_rd_E7");
        check("bit_rd_E7_rbit", 32'(rbit), 32'd1);
        check("bit_rd_E7_rdata", 32'(rdata), 32'h80);

        // Simultaneous requests: CPU first, debug next.
        @(negedge clock);
        cpu_we = 0; cpu_is_bit = 0; cpu_addr = 8'h40; cpu_req = 1;
        dbg_we = 0; dbg_is_bit = 0; dbg_addr = 8'h41; dbg_req = 1;
        n = 0;
        while (order.size() < 2 && n < 30) begin
            @(negedge clock);
            n++;
            if (cpu_ack) begin
                order.push_back(0); cpu_req = 0;
                check("simul_cpu_rdata", 32'(rdata), 32'(exp_mem[8'h40]));
            end
            if (dbg_ack) begin
                order.push_back(1); dbg_req = 0;
                check("simul_dbg_rdata", 32'(rdata), 32'(exp_mem[8'h41]));
            end
        end
        cpu_req = 0; dbg_req = 0;
        check("simul_ack_count", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            check("simul_first_cpu", 32'(order[0]), 32'd0);
            check("simul_second_dbg", 32'(order[1]), 32'd1);
        end

        // Starvation: CPU requests back-to-back while debug waits.
        @(negedge clock);
        cpu_we = 0; cpu_is_bit = 0; cpu_addr = 8'h50; cpu_req = 1;
        dbg_we = 0; dbg_is_bit = 1; dbg_addr = 8'h85; dbg_req = 1;
        cpu_cnt = 0; dbg_seen = 0; n = 0;
        while (dbg_seen < 2 && n < 400) begin
            @(negedge clock);
            n++;
            if (cpu_ack) cpu_cnt++;
            if (dbg_ack) begin
                dbg_seen++;
                starve_runs.push_back(cpu_cnt);
                cpu_cnt = 0;
                check("starve_dbg_rbit", 32'(rbit), 32'((exp_mem[8'h80] >> 5) & 8'd1));
                if (dbg_seen == 2) begin cpu_req = 0; dbg_req = 0; end
            end
        end
        cpu_req = 0; dbg_req = 0;
        check("starve_dbg_grants", 32'(starve_runs.size()), 32'd2);
        if (starve_runs.size() == 2) begin
            check("starve_first_run", 32'(starve_runs[0]), 32'd8);
            check("starve_second_run", 32'(starve_runs[1]), 32'd8);
        end

        // Random single-requester traffic.
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    "rand");
        end

        // Reset during the write-back of a bit write.
        keep = exp_mem[8'h2F];
        @(negedge clock);
        cpu_we = 1; cpu_is_bit = 1; cpu_addr = 8'h7F; cpu_wbit = ~keep[7]; cpu_req = 1;
        n = 0; got_wr = 0;
        while (!got_wr && n < 10) begin
            @(negedge clock);
            n++;
            if (ram_wr) got_wr = 1;
        end
        check("rst_wb_reached", 32'(got_wr), 32'd1);
        check("rst_wb_addr", 32'(ram_addr), 32'h2F);
        #1 reset = 1;
        #1;
        check("rst_wb_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_wb_busy", 32'(busy), 32'd0);
        check("rst_wb_cpu_ack", 32'(cpu_ack), 32'd0);
        cpu_req = 0;
        @(negedge clock);
        reset = 0;
        run_txn(0, 0, 0, 8'h2F, 8'h00, 0, "rst_wb_readback");
        check("rst_wb_unmodified", 32'(rdata), 32'(keep));

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
